// File: rtl/inst_fetch_queue.sv
// Fetch stage: holds the PC, reads the combinational instruction memory and
// queues {pc, inst} pairs in a DEPTH-entry FIFO presented to decode.
// Optional build macro FETCH_ZERO_HALT_EN: a fetched all-zero word stops
// fetching (out_halted) until the next redirect or reset.
module inst_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  output logic [63:0] out_imem_addr,
  input  logic [31:0] in_imem_inst,
  input  logic        in_redirect,
  input  logic [63:0] in_redirect_pc,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [63:0]   PC_INIT  = {RESET_PC[63:2], 2'b00};

  logic [63:0]   pc_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   inst_mem [DEPTH];
  logic [63:0]   pc_mem   [DEPTH];

  logic pop, fetch, push, halted;

  assign out_valid     = (count_q != '0);
  assign pop           = out_valid & in_ready;
  assign fetch         = ~in_redirect & ~halted & ((count_q < DEPTH_C) | pop);
  assign out_imem_addr = {2'b00, pc_q[63:2]};
  assign out_inst      = out_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign out_pc        = out_valid ? pc_mem[rd_ptr_q]   : 64'h0;

`ifdef FETCH_ZERO_HALT_EN
  logic halted_q;

  // A zero word is the end-of-image marker: it is dropped and fetch stops.
  assign push = fetch & (in_imem_inst != 32'h0);

  // Halt latch, cleared only by redirect or reset.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      halted_q <= 1'b0;
    end else if (in_redirect) begin
      halted_q <= 1'b0;
    end else if (fetch && !push) begin
      halted_q <= 1'b1;
    end
  end

  assign halted     = halted_q;
  assign out_halted = halted_q;
`else
  assign push       = fetch;
  assign halted     = 1'b0;
  assign out_halted = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // PC, pointers and occupancy; redirect overrides any push/pop this cycle.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pc_q     <= PC_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (in_redirect) begin
      pc_q     <= {in_redirect_pc[63:2], 2'b00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_q     <= pc_q + 64'd4;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Entry storage; the memory bus is only captured on push edges.
  always_ff @(posedge in_clk) begin
    if (push && !in_redirect) begin
      inst_mem[wr_ptr_q] <= in_imem_inst;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=2, RESET_PC=0).
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        halted;
  logic [63:0] zero_addr;

  int total = 0;
  int bad   = 0;

  inst_fetch_queue #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .out_imem_addr (imem_addr),
    .in_imem_inst  (imem_inst),
    .in_redirect   (redirect),
    .in_redirect_pc(redirect_pc),
    .out_valid     (valid),
    .in_ready      (ready),
    .out_inst      (inst),
    .out_pc        (pc),
    .out_halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word w holds {C0, w[23:0]}, except zero_addr which holds 0.
  always_comb begin
    imem_inst = {8'hC0, imem_addr[23:0]};
    if (imem_addr == zero_addr) imem_inst = 32'h0;
  end

  function automatic logic [31:0] word_at(input logic [63:0] byte_pc);
    logic [63:0] w;
    w = {2'b00, byte_pc[63:2]};
    return {8'hC0, w[23:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (pc !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    rst_n = 1'b1;
    #2;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rel_valid got=%b exp=0", valid); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (valid !== 1'b1 || pc !== 64'(4 * k) || inst !== word_at(64'(4 * k))) begin
        bad++;
        $display("FAIL stream%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 k, valid, pc, inst, 64'(4 * k), word_at(64'(4 * k)));
      end
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    total++; if (valid !== 1'b1 || pc !== 64'h0) begin bad++; $display("FAIL bp_hold got v=%b pc=%h exp v=1 pc=0", valid, pc); end
    total++; if (imem_addr !== 64'd2) begin bad++; $display("FAIL bp_addr got=%h exp=2", imem_addr); end
    ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      total++;
      if (valid !== 1'b1 || pc !== 64'(4 * k) || inst !== word_at(64'(4 * k))) begin
        bad++;
        $display("FAIL bp_drain%0d got v=%b pc=%h exp pc=%h", k, valid, pc, 64'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_full();
    ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) step();
    redirect = 1'b1; redirect_pc = 64'h103; ready = 1'b1;
    step();
    redirect = 1'b0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rd_kill got=%b exp=0", valid); end
    total++; if (imem_addr !== 64'h40) begin bad++; $display("FAIL rd_addr got=%h exp=40", imem_addr); end
    step();
    total++;
    if (valid !== 1'b1 || pc !== 64'h100 || inst !== word_at(64'h100)) begin
      bad++; $display("FAIL rd_head got v=%b pc=%h inst=%h exp pc=100", valid, pc, inst);
    end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) step();
    rst_n = 1'b0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", valid); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL ar_addr got=%h exp=0", imem_addr); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (valid !== 1'b1 || pc !== 64'h0) begin bad++; $display("FAIL ar_restart got v=%b pc=%h exp pc=0", valid, pc); end
  endtask

  task automatic test_wrap();
    ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 64'h3FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wr_addr got=%h exp=3fffffffffffffff", imem_addr); end
    step();
    total++; if (valid !== 1'b1 || pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wr_top got v=%b pc=%h", valid, pc); end
    step();
    total++; if (valid !== 1'b1 || pc !== 64'h0 || inst !== word_at(64'h0)) begin bad++; $display("FAIL wr_zero got v=%b pc=%h", valid, pc); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'h200;
    step();
    redirect_pc = 64'h300;
    step();
    redirect = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_kill got=%b exp=0", valid); end
    step();
    total++; if (valid !== 1'b1 || pc !== 64'h300) begin bad++; $display("FAIL b2b_head got v=%b pc=%h exp pc=300", valid, pc); end
  endtask

  task automatic test_zero_word();
    zero_addr = 64'd2;
    ready = 1'b1;
    do_reset();
    step();
    step();
    total++; if (valid !== 1'b1 || pc !== 64'h4) begin bad++; $display("FAIL zw_b got v=%b pc=%h exp pc=4", valid, pc); end
    step();
`ifdef FETCH_ZERO_HALT_EN
    for (int k = 0; k < 10; k++) begin
      total++;
      if (valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 64'd2) begin
        bad++; $display("FAIL zw_halt%0d got v=%b h=%b addr=%h exp v=0 h=1 addr=2", k, valid, halted, imem_addr);
      end
      step();
    end
    redirect = 1'b1; redirect_pc = 64'h0;
    step();
    redirect = 1'b0;
    total++; if (halted !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL zw_clear got h=%b v=%b exp h=0 v=0", halted, valid); end
    step();
    total++; if (valid !== 1'b1 || pc !== 64'h0 || inst !== word_at(64'h0)) begin bad++; $display("FAIL zw_again got v=%b pc=%h", valid, pc); end
`else
    total++; if (valid !== 1'b1 || pc !== 64'h8 || inst !== 32'h0) begin bad++; $display("FAIL zw_push got v=%b pc=%h inst=%h exp pc=8 inst=0", valid, pc, inst); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL zw_nohalt got=%b exp=0", halted); end
`endif
    zero_addr = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  initial begin
    zero_addr   = 64'hFFFF_FFFF_FFFF_FFFF;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ready       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    test_zero_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
